led_position_ctrl: RTL and testbench
====================================

# led_position_ctrl

Parametrised single-lit-LED position controller for the board LED bank. It keeps exactly one of `NUM_LEDS` outputs lit and moves it with debounced left/right buttons, with hold-to-repeat. A parameter selects wrap-around or saturation at the ends of the bank, and an autonomous bounce-scan mode can be enabled at run time. It sits between the raw push-button pins and the LED pins, and also exports the lit index for display logic.

## Interface
Parameters:
- `NUM_LEDS`, 8: LED count; must be ≥ 2. `PW = $clog2(NUM_LEDS)`.
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable samples a button must hold before its debounced level changes (≥ 1).
- `HOLD_CYCLES`, 23_000_000: repeat period while a button is held, and step period in auto mode (≥ 2).
- `WRAP`, 1: 1 = wrap at the ends; 0 = saturate at the ends.

Ports:
- `clk_100mhz`  in  1: sole clock, all state on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `btn_left`  in  1: raw left button, active-high, already synchronised to `clk_100mhz`.
- `btn_right`  in  1: raw right button, active-high, already synchronised to `clk_100mhz`.
- `mode_auto`  in  1: 1 = bounce-scan mode; buttons are ignored while it is high.
- `led_out`  out  NUM_LEDS: registered one-hot, bit `pos` lit.
- `pos`  out  PW: registered index of the lit LED.

## Operation
- Reset values: `pos` = 0, `led_out` = 1 (bit 0), FSM = IDLE, scan direction = up. Both debounced levels and all counters are cleared to 0.
- Debounce: each button feeds a counter. The counter is cleared whenever the raw input equals the debounced level. When the raw input differs from the debounced level for `DEBOUNCE_CYCLES` consecutive cycles, the debounced level toggles. `rise` is a one-cycle pulse when the debounced level goes 0→1.
- Step left = `pos + 1` (toward MSB). Step right = `pos - 1`.
- Bank ends with `WRAP` = 1: a left step at `NUM_LEDS-1` goes to 0, and a right step at 0 goes to `NUM_LEDS-1`.
- Bank ends with `WRAP` = 0: a step past either end is a no-op, and the repeat timer keeps running.
- FSM states: IDLE, HOLD_L, HOLD_R, AUTO.
  - IDLE: if `mode_auto` = 1, go to AUTO. Else if exactly one `rise` fires and the other button's debounced level is 0, step once and enter HOLD_L or HOLD_R with the repeat timer cleared. A `rise` while the other button is debounced-high causes no step and no state change.
  - HOLD_x: the timer counts 0..`HOLD_CYCLES-1`. At the terminal count, step once and clear the timer.
  - HOLD_x exits to IDLE, with no step and the timer cleared, when any of these occurs: the debounced level of x falls, the other button's debounced level rises (both pressed), or `mode_auto` = 1 (→ AUTO on the next cycle).
  - After a both-pressed exit, the still-held button does not resume. Movement needs a fresh `rise`.
  - AUTO: the timer runs from 0. At each terminal count, step in the scan direction. The direction flips to down on reaching `NUM_LEDS-1` and to up on reaching 0. AUTO always bounces; `WRAP` is ignored.
  - AUTO → IDLE when `mode_auto` = 0. `pos` and the direction are retained, and a held button needs a fresh `rise`.
- `led_out` is always exactly one-hot and always consistent with `pos` in the same cycle.

## Timing
- Raw press: the first cycle sampled high is cycle 0. The debounced level rises at edge `DEBOUNCE_CYCLES` and `pos` changes at edge `DEBOUNCE_CYCLES+1`.
- Held: further steps occur every `HOLD_CYCLES` cycles after the first step.
- Release: the debounced level falls `DEBOUNCE_CYCLES` cycles after the raw level falls. The state is IDLE on the following edge, with no step on that edge.
- AUTO: the first step occurs `HOLD_CYCLES` cycles after entering AUTO, then every `HOLD_CYCLES` cycles.
- `rst` mid-operation: everything returns to reset values on that edge. A button held through reset registers as a new press `DEBOUNCE_CYCLES` cycles after `rst` deasserts.
- There is no combinational path from inputs to outputs.

## Structure
- Shared package `led_ctrl_pkg`: FSM state encoding (IDLE/HOLD_L/HOLD_R/AUTO) and direction constants (DIR_UP/DIR_DOWN).
- Sub-module `btn_debounce`, parameter `DEBOUNCE_CYCLES`, instantiated twice. Ports: `clk_100mhz`, `rst`, `raw`, `level`, `rise`.
- Top-level contents: FSM, repeat/scan timer (width `$clog2(HOLD_CYCLES)`), `pos` register, and a registered one-hot decoder.

## Test plan
Bench parameters: `NUM_LEDS` = 8, `DEBOUNCE_CYCLES` = 4, `HOLD_CYCLES` = 10.
- Tap left: raw high for 6 cycles after reset → `pos` 0→1 at edge 5 and `led_out` = 8'b0000_0010. No further step.
- Glitch: raw left high for 3 cycles only → no step.
- Wrap (`WRAP` = 1): hold right from `pos` = 0 for 30 cycles → `pos` = 7 at edge 5, 6 at edge 15, 5 at edge 25.
- Saturate (`WRAP` = 0): hold left from `pos` = 7 for 30 cycles → `pos` stays 7 and `led_out` stays 8'b1000_0000.
- Both pressed: hold left, then press right 12 cycles later → stepping stops. Release right while left is still held → no step until left is released and pressed again.
- Auto and reset: `mode_auto` = 1 from `pos` = 6 → `pos` sequence 7, 6, 5 at 10-cycle intervals. Assert `rst` mid-run → `pos` = 0 and `led_out` = 1 on the next edge.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// Shared encodings for the LED position controller: FSM states and scan direction.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_L = 2'd1,
    HOLD_R = 2'd2,
    AUTO   = 2'd3
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/btn_debounce.sv
// Push-button debouncer: the level follows raw only after it has disagreed long enough.
// rise is a registered one-cycle pulse on the 0->1 level change.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_100mhz,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES);

  logic [CW-1:0] cnt;

  // Edge numbering: the first differing sample is edge 0, so the level flips at edge DEBOUNCE_CYCLES.
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (raw == level) begin
        cnt <= '0;
      end else if (cnt == CNT_TC) begin
        cnt   <= '0;
        level <= raw;
        rise  <= raw;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/led_position_ctrl.sv
// Single-lit LED position controller: debounced left/right stepping with hold-to-repeat,
// wrap or saturate at the bank ends, and a run-time bounce-scan mode.
//
// state  | meaning
// IDLE   | waiting for a fresh button rise or mode_auto
// HOLD_L | left held; step toward MSB every HOLD_CYCLES
// HOLD_R | right held; step toward LSB every HOLD_CYCLES
// AUTO   | bounce scan, one step every HOLD_CYCLES, buttons ignored
module led_position_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int NUM_LEDS        = 8,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 23_000_000,
  parameter bit WRAP            = 1'b1
) (
  input  logic                        clk_100mhz,
  input  logic                        rst,
  input  logic                        btn_left,
  input  logic                        btn_right,
  input  logic                        mode_auto,
  output logic [NUM_LEDS-1:0]         led_out,
  output logic [$clog2(NUM_LEDS)-1:0] pos
);

  localparam int PW = $clog2(NUM_LEDS);
  localparam int TW = $clog2(HOLD_CYCLES);
  localparam logic [PW-1:0]       POS_MAX = PW'(NUM_LEDS - 1);
  localparam logic [PW-1:0]       POS_TOP = PW'(NUM_LEDS - 2);
  localparam logic [PW-1:0]       POS_ONE = PW'(1);
  localparam logic [TW-1:0]       TMR_TC  = TW'(HOLD_CYCLES - 1);
  localparam logic [NUM_LEDS-1:0] LED_ONE = {{(NUM_LEDS - 1){1'b0}}, 1'b1};

  logic level_l, rise_l, level_r, rise_r;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .raw        (btn_left),
    .level      (level_l),
    .rise       (rise_l)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .raw        (btn_right),
    .level      (level_r),
    .rise       (rise_r)
  );

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [PW-1:0] pos_nxt, pos_left, pos_right;
  logic          dir, dir_nxt;
  logic          at_max, at_min, tmr_tc;

  // Manual steps honour WRAP; with saturation the step at an end is simply a no-op.
  always_comb begin
    at_max    = (pos == POS_MAX);
    at_min    = (pos == '0);
    tmr_tc    = (timer == TMR_TC);
    pos_left  = at_max ? (WRAP ? '0 : pos) : pos + POS_ONE;
    pos_right = at_min ? (WRAP ? POS_MAX : pos) : pos - POS_ONE;
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = '0;
    pos_nxt   = pos;
    dir_nxt   = dir;
    case (state)
      IDLE: begin
        if (mode_auto) begin
          state_nxt = AUTO;
        end else if (rise_l && !rise_r && !level_r) begin
          pos_nxt   = pos_left;
          state_nxt = HOLD_L;
        end else if (rise_r && !rise_l && !level_l) begin
          pos_nxt   = pos_right;
          state_nxt = HOLD_R;
        end
      end
      HOLD_L: begin
        if (mode_auto || !level_l || level_r) begin
          state_nxt = IDLE;
        end else if (tmr_tc) begin
          pos_nxt = pos_left;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      HOLD_R: begin
        if (mode_auto || !level_r || level_l) begin
          state_nxt = IDLE;
        end else if (tmr_tc) begin
          pos_nxt = pos_right;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      AUTO: begin
        if (!mode_auto) begin
          state_nxt = IDLE;
        end else if (tmr_tc) begin
          // Bounce always; a stale direction at an end turns around rather than overrunning.
          if (dir == DIR_UP) begin
            if (at_max) begin
              pos_nxt = pos - POS_ONE;
              dir_nxt = DIR_DOWN;
            end else begin
              pos_nxt = pos + POS_ONE;
              if (pos == POS_TOP) dir_nxt = DIR_DOWN;
            end
          end else begin
            if (at_min) begin
              pos_nxt = pos + POS_ONE;
              dir_nxt = DIR_UP;
            end else begin
              pos_nxt = pos - POS_ONE;
              if (pos == POS_ONE) dir_nxt = DIR_UP;
            end
          end
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // led_out is decoded from pos_nxt so both registers change on the same edge.
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      pos     <= '0;
      dir     <= DIR_UP;
      led_out <= LED_ONE;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      pos     <= pos_nxt;
      dir     <= dir_nxt;
      led_out <= LED_ONE << pos_nxt;
    end
  end

endmodule

// File: tb/tb_led_position_ctrl.sv
// Bench for led_position_ctrl: one wrapping and one saturating instance, expected
// positions queued per edge and compared as each edge is reached.
module tb_led_position_ctrl;

  logic clk_100mhz = 1'b0;
  always #5 clk_100mhz = ~clk_100mhz;

  logic       rst, btn_left, btn_right, mode_auto;
  logic       s_rst, s_left, s_right;
  logic [7:0] led_w, led_s;
  logic [2:0] pos_w, pos_s;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         edge_n;
    logic [2:0] pos;
  } exp_t;

  exp_t q[$];

  led_position_ctrl #(
    .NUM_LEDS(8), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .WRAP(1'b1)
  ) dut_wrap (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .mode_auto  (mode_auto),
    .led_out    (led_w),
    .pos        (pos_w)
  );

  led_position_ctrl #(
    .NUM_LEDS(8), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .WRAP(1'b0)
  ) dut_sat (
    .clk_100mhz (clk_100mhz),
    .rst        (s_rst),
    .btn_left   (s_left),
    .btn_right  (s_right),
    .mode_auto  (1'b0),
    .led_out    (led_s),
    .pos        (pos_s)
  );

  task automatic push(input int e, input logic [2:0] p);
    exp_t x;
    x.edge_n = e;
    x.pos    = p;
    q.push_back(x);
  endtask

  task automatic apply_reset();
    rst = 1'b1; s_rst = 1'b1;
    btn_left = 1'b0; btn_right = 1'b0; mode_auto = 1'b0;
    s_left = 1'b0; s_right = 1'b0;
    q.delete();
    @(posedge clk_100mhz); #1;
    rst = 1'b0; s_rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_rst = 1'b1;
    btn_left = 1'b0; btn_right = 1'b0; mode_auto = 1'b0;
    s_left = 1'b0; s_right = 1'b0;
    repeat (2) begin @(posedge clk_100mhz); #1; end
    checks += 4;
    if (pos_w !== 3'd0) begin errors++; $display("FAIL reset pos_w: got %0d expected 0", pos_w); end
    if (led_w !== 8'h01) begin errors++; $display("FAIL reset led_w: got %b expected 00000001", led_w); end
    if (pos_s !== 3'd0) begin errors++; $display("FAIL reset pos_s: got %0d expected 0", pos_s); end
    if (led_s !== 8'h01) begin errors++; $display("FAIL reset led_s: got %b expected 00000001", led_s); end
    rst = 1'b0; s_rst = 1'b0;
  endtask

  task automatic test_tap();
    exp_t e;
    logic [7:0] el;
    apply_reset();
    push(4, 3'd0); push(5, 3'd1); push(12, 3'd1); push(24, 3'd1);
    for (int i = 0; i <= 24; i++) begin
      btn_left = (i < 6);
      @(posedge clk_100mhz); #1;
      while (q.size() > 0 && q[0].edge_n == i) begin
        e = q.pop_front();
        el = 8'b1 << e.pos;
        checks += 2;
        if (pos_w !== e.pos) begin errors++; $display("FAIL tap pos edge %0d: got %0d expected %0d", i, pos_w, e.pos); end
        if (led_w !== el) begin errors++; $display("FAIL tap led edge %0d: got %b expected %b", i, led_w, el); end
      end
    end
  endtask

  task automatic test_glitch();
    exp_t e;
    logic [7:0] el;
    apply_reset();
    push(4, 3'd0); push(8, 3'd0); push(15, 3'd0);
    for (int i = 0; i <= 15; i++) begin
      btn_left = (i < 3);
      @(posedge clk_100mhz); #1;
      while (q.size() > 0 && q[0].edge_n == i) begin
        e = q.pop_front();
        el = 8'b1 << e.pos;
        checks += 2;
        if (pos_w !== e.pos) begin errors++; $display("FAIL glitch pos edge %0d: got %0d expected %0d", i, pos_w, e.pos); end
        if (led_w !== el) begin errors++; $display("FAIL glitch led edge %0d: got %b expected %b", i, led_w, el); end
      end
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    logic [7:0] el;
    apply_reset();
    push(4, 3'd0); push(5, 3'd7); push(14, 3'd7); push(15, 3'd6);
    push(24, 3'd6); push(25, 3'd5); push(35, 3'd5); push(40, 3'd5);
    for (int i = 0; i <= 40; i++) begin
      btn_right = (i < 30);
      @(posedge clk_100mhz); #1;
      while (q.size() > 0 && q[0].edge_n == i) begin
        e = q.pop_front();
        el = 8'b1 << e.pos;
        checks += 2;
        if (pos_w !== e.pos) begin errors++; $display("FAIL wrap pos edge %0d: got %0d expected %0d", i, pos_w, e.pos); end
        if (led_w !== el) begin errors++; $display("FAIL wrap led edge %0d: got %b expected %b", i, led_w, el); end
      end
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    logic [7:0] el;
    apply_reset();
    for (int k = 1; k <= 7; k++) push(5 + 10 * (k - 1), 3'(k));
    push(66, 3'd7); push(75, 3'd7); push(85, 3'd7); push(99, 3'd7);
    for (int i = 0; i <= 99; i++) begin
      s_left = 1'b1;
      @(posedge clk_100mhz); #1;
      while (q.size() > 0 && q[0].edge_n == i) begin
        e = q.pop_front();
        el = 8'b1 << e.pos;
        checks += 2;
        if (pos_s !== e.pos) begin errors++; $display("FAIL sat_left pos edge %0d: got %0d expected %0d", i, pos_s, e.pos); end
        if (led_s !== el) begin errors++; $display("FAIL sat_left led edge %0d: got %b expected %b", i, led_s, el); end
      end
    end
    apply_reset();
    push(5, 3'd0); push(15, 3'd0); push(19, 3'd0);
    for (int i = 0; i <= 19; i++) begin
      s_right = 1'b1;
      @(posedge clk_100mhz); #1;
      while (q.size() > 0 && q[0].edge_n == i) begin
        e = q.pop_front();
        el = 8'b1 << e.pos;
        checks += 2;
        if (pos_s !== e.pos) begin errors++; $display("FAIL sat_right pos edge %0d: got %0d expected %0d", i, pos_s, e.pos); end
        if (led_s !== el) begin errors++; $display("FAIL sat_right led edge %0d: got %b expected %b", i, led_s, el); end
      end
    end
    s_right = 1'b0;
  endtask

  task automatic test_both_pressed();
    exp_t e;
    logic [7:0] el;
    apply_reset();
    push(5, 3'd1); push(15, 3'd2); push(17, 3'd2); push(25, 3'd2); push(40, 3'd2);
    push(59, 3'd2); push(74, 3'd2); push(75, 3'd3); push(90, 3'd3);
    for (int i = 0; i <= 90; i++) begin
      btn_left  = (i < 60) || (i >= 70 && i < 76);
      btn_right = (i >= 12 && i < 30);
      @(posedge clk_100mhz); #1;
      while (q.size() > 0 && q[0].edge_n == i) begin
        e = q.pop_front();
        el = 8'b1 << e.pos;
        checks += 2;
        if (pos_w !== e.pos) begin errors++; $display("FAIL both pos edge %0d: got %0d expected %0d", i, pos_w, e.pos); end
        if (led_w !== el) begin errors++; $display("FAIL both led edge %0d: got %b expected %b", i, led_w, el); end
      end
    end
  endtask

  task automatic test_auto_reset();
    exp_t e;
    logic [7:0] el;
    apply_reset();
    push(55, 3'd6); push(70, 3'd6); push(79, 3'd6); push(80, 3'd7); push(89, 3'd7);
    push(90, 3'd6); push(100, 3'd5); push(105, 3'd0); push(106, 3'd0); push(116, 3'd1);
    for (int i = 0; i <= 118; i++) begin
      btn_left  = (i < 58);
      mode_auto = (i >= 70);
      rst       = (i == 105);
      @(posedge clk_100mhz); #1;
      while (q.size() > 0 && q[0].edge_n == i) begin
        e = q.pop_front();
        el = 8'b1 << e.pos;
        checks += 2;
        if (pos_w !== e.pos) begin errors++; $display("FAIL auto pos edge %0d: got %0d expected %0d", i, pos_w, e.pos); end
        if (led_w !== el) begin errors++; $display("FAIL auto led edge %0d: got %b expected %b", i, led_w, el); end
      end
    end
    rst = 1'b0;
    mode_auto = 1'b0;
  endtask

  task automatic test_reset_held();
    exp_t e;
    logic [7:0] el;
    apply_reset();
    push(5, 3'd1); push(10, 3'd0); push(15, 3'd0); push(16, 3'd1);
    push(26, 3'd2); push(30, 3'd2);
    for (int i = 0; i <= 30; i++) begin
      btn_left = (i < 22);
      rst      = (i == 10);
      @(posedge clk_100mhz); #1;
      while (q.size() > 0 && q[0].edge_n == i) begin
        e = q.pop_front();
        el = 8'b1 << e.pos;
        checks += 2;
        if (pos_w !== e.pos) begin errors++; $display("FAIL held_rst pos edge %0d: got %0d expected %0d", i, pos_w, e.pos); end
        if (led_w !== el) begin errors++; $display("FAIL held_rst led edge %0d: got %b expected %b", i, led_w, el); end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tap();
    test_glitch();
    test_wrap();
    test_saturate();
    test_both_pressed();
    test_auto_reset();
    test_reset_held();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
